// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU data port, debug readout)
// and the single-port memory macro. The arbiter takes the slave view.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              CPU_REQ;
    logic              CPU_WE;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [DATA_W-1:0] CPU_WDATA;
    logic [DATA_W-1:0] CPU_RDATA;
    logic              CPU_STALL;

    logic              DBG_REQ;
    logic [ADDR_W-1:0] DBG_ADDR;
    logic              DBG_ACK;
    logic [DATA_W-1:0] DBG_RDATA;

    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;

    logic              BUSY;

    modport master (
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
        input  CPU_RDATA, CPU_STALL,
        output DBG_REQ, DBG_ADDR,
        input  DBG_ACK, DBG_RDATA,
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_RDATA,
        input  BUSY
    );

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
        output CPU_RDATA, CPU_STALL,
        input  DBG_REQ, DBG_ADDR,
        output DBG_ACK, DBG_RDATA,
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_RDATA,
        output BUSY
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Owner of the single-port data memory: zero-fills it after reset, then arbitrates between the
// CPU data port and a starvation-protected debug read port, stalling the core when it loses.
module data_mem_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int CLR_EN     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                RESETn,
    data_mem_arbiter_if.slave   bus
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {CLEAR, IDLE, CPU_RD, DBG_RD} state_t;
    localparam state_t RST_STATE = (CLR_EN != 0) ? CLEAR : IDLE;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [SC_W-1:0]   starve_cnt, starve_nxt;
    logic              dbg_win;
    logic              dbg_ack_p1;
    logic [DATA_W-1:0] dbg_rdata_p1;

    logic              mem_en, mem_we, cpu_stall, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, cpu_rdata;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        if (v >= SC_W'(STARVE_MAX))
            return SC_W'(STARVE_MAX);
        else
            return v + SC_W'(1);
    endfunction

    always_comb begin
        dbg_win    = bus.DBG_REQ && !dbg_ack_p1 &&
                     ((starve_cnt == SC_W'(STARVE_MAX)) || !bus.CPU_REQ);
        state_nxt  = state;
        starve_nxt = starve_cnt;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        busy       = 1'b0;
        case (state)
            CLEAR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                busy      = 1'b1;
                cpu_stall = bus.CPU_REQ;
                if (clr_addr == '1)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (dbg_win) begin
                    mem_en     = 1'b1;
                    mem_addr   = bus.DBG_ADDR;
                    cpu_stall  = bus.CPU_REQ;
                    starve_nxt = '0;
                    state_nxt  = DBG_RD;
                end else if (bus.CPU_REQ) begin
                    mem_en    = 1'b1;
                    mem_we    = bus.CPU_WE;
                    mem_addr  = bus.CPU_ADDR;
                    mem_wdata = bus.CPU_WDATA;
                    cpu_stall = !bus.CPU_WE;
                    if (!bus.CPU_WE)
                        state_nxt = CPU_RD;
                    // A pending debug request just lost this slot to the core.
                    if (bus.DBG_REQ && !dbg_ack_p1)
                        starve_nxt = sat_inc(starve_cnt);
                end
            end
            CPU_RD: begin
                cpu_rdata = bus.MEM_RDATA;
                state_nxt = IDLE;
            end
            DBG_RD: begin
                cpu_stall = bus.CPU_REQ;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.DBG_REQ)
            starve_nxt = '0;
        // Reset must not let the CLEAR state drive the macro before the fill actually starts.
        if (!RESETn) begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            cpu_stall = 1'b0;
            cpu_rdata = '0;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state        <= RST_STATE;
            clr_addr     <= '0;
            starve_cnt   <= '0;
            dbg_ack_p1   <= 1'b0;
            dbg_rdata_p1 <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (state == CLEAR)
                clr_addr <= clr_addr + ADDR_W'(1);
            // Stage p1: debug read data captured the cycle after the memory read.
            dbg_ack_p1 <= (state == DBG_RD);
            if (state == DBG_RD)
                dbg_rdata_p1 <= bus.MEM_RDATA;
        end
    end

    assign bus.MEM_EN    = mem_en;
    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;
    assign bus.CPU_STALL = cpu_stall;
    assign bus.CPU_RDATA = cpu_rdata;
    assign bus.BUSY      = busy;
    assign bus.DBG_ACK   = dbg_ack_p1;
    assign bus.DBG_RDATA = dbg_rdata_p1;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: zero-fill, CPU read/write, debug readout, starvation
// override, CPU stall during fill, and reset abandoning a debug read.
module tb_data_mem_arbiter;
    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    logic preload = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;

    logic [31:0] mem [0:2047];

    data_mem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus ();

    data_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .CLR_EN(1), .STARVE_MAX(4)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read memory macro model, one cycle latency.
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'hA5A5A5A5;
        end else if (bus.MEM_EN) begin
            if (bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
            else            bus.MEM_RDATA <= mem[bus.MEM_ADDR];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_write(input logic [10:0] a, input logic [31:0] d);
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = a; bus.CPU_WDATA = d;
        @(negedge CLK);
        chk("wr_stall", bus.CPU_STALL, 0);
        chk("wr_mem_we", bus.MEM_WE, 1);
        step();
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0;
    endtask

    task automatic cpu_read(input logic [10:0] a, input logic [31:0] exp);
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADDR = a;
        @(negedge CLK);
        chk("rd_stall_issue", bus.CPU_STALL, 1);
        step();
        @(negedge CLK);
        chk("rd_stall_done", bus.CPU_STALL, 0);
        chk("rd_data", bus.CPU_RDATA, exp);
        chk("rd_mem_en", bus.MEM_EN, 0);
        step();
        bus.CPU_REQ = 1'b0;
    endtask

    task automatic dbg_read(input logic [10:0] a, input logic [31:0] exp);
        int n;
        n = 0;
        bus.DBG_REQ = 1'b1; bus.DBG_ADDR = a;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.DBG_ACK) break;
            n++;
        end
        chk("dbg_latency", n, 2);
        chk("dbg_data", bus.DBG_RDATA, exp);
        chk("dbg_no_regrant", bus.MEM_EN, 0);
        step();
        bus.DBG_REQ = 1'b0;
        @(negedge CLK);
        chk("dbg_ack_pulse", bus.DBG_ACK, 0);
        step();
    endtask

    initial begin
        logic [11:0] exp_stall;
        logic [11:0] rd_cyc;
        int nbusy, nstall, nack, nz;
        exp_stall = 12'b0111_0101_0101;
        rd_cyc    = 12'b1000_1010_1010;
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADDR = '0; bus.CPU_WDATA = '0;
        bus.DBG_REQ = 1'b0; bus.DBG_ADDR = '0;

        // T1: reset state, then zero-fill of the preloaded memory
        step();
        preload = 1'b0;
        step();
        @(negedge CLK);
        chk("rst_mem_en", bus.MEM_EN, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_ack", bus.DBG_ACK, 0);
        chk("rst_dbg_rdata", bus.DBG_RDATA, 0);
        chk("rst_cpu_rdata", bus.CPU_RDATA, 0);
        step();
        RESETn = 1'b1;
        nbusy = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (!bus.BUSY) break;
            nbusy++;
        end
        chk("clr_cycles", nbusy, 2048);
        nz = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] != 32'h0) nz++;
        chk("clr_nonzero_words", nz, 0);
        step();

        // T2 / T3: CPU write then read, debug readout with idle CPU
        cpu_write(11'h010, 32'h12345678);
        cpu_read(11'h010, 32'h12345678);
        dbg_read(11'h010, 32'h12345678);

        // T4: CPU reads back-to-back while a debug request is held
        cpu_write(11'h020, 32'hCAFEF00D);
        cpu_write(11'h030, 32'h0BADBEEF);
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADDR = 11'h030;
        bus.DBG_REQ = 1'b1; bus.DBG_ADDR = 11'h020;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            chk($sformatf("starve_stall_c%0d", c), bus.CPU_STALL, exp_stall[c]);
            chk($sformatf("starve_ack_c%0d", c), bus.DBG_ACK, (c == 10));
            if (rd_cyc[c]) chk($sformatf("starve_cpu_data_c%0d", c), bus.CPU_RDATA, 32'h0BADBEEF);
            if (c == 8) chk("starve_grant_addr", bus.MEM_ADDR, 11'h020);
            if (c == 10) chk("starve_dbg_data", bus.DBG_RDATA, 32'hCAFEF00D);
            step();
            if (c == 10) bus.DBG_REQ = 1'b0;
        end
        bus.CPU_REQ = 1'b0;

        // T6: reset during DBG_RD
        bus.DBG_REQ = 1'b1; bus.DBG_ADDR = 11'h020;
        step();
        RESETn = 1'b0;
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 11'h055; bus.CPU_WDATA = 32'h5555AAAA;
        @(negedge CLK);
        chk("rst2_ack", bus.DBG_ACK, 0);
        chk("rst2_mem_en", bus.MEM_EN, 0);
        chk("rst2_stall", bus.CPU_STALL, 0);
        chk("rst2_dbg_rdata", bus.DBG_RDATA, 0);
        step();
        bus.DBG_REQ = 1'b0;
        @(negedge CLK);
        chk("rst2_ack_held", bus.DBG_ACK, 0);
        bus.DBG_REQ = 1'b1; bus.DBG_ADDR = 11'h010;
        step();
        RESETn = 1'b1;

        // T5: CPU write held across the whole fill, debug request waits too
        nbusy = 0; nstall = 0; nack = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (!bus.BUSY) break;
            if (i == 0) chk("clr2_start_addr", bus.MEM_ADDR, 0);
            nbusy++;
            if (bus.CPU_STALL) nstall++;
            if (bus.DBG_ACK) nack++;
        end
        chk("clr2_cycles", nbusy, 2048);
        chk("clr2_stall_cycles", nstall, 2048);
        chk("clr2_acks", nack, 0);
        chk("post_clr_stall", bus.CPU_STALL, 0);
        chk("post_clr_we", bus.MEM_WE, 1);
        chk("post_clr_addr", bus.MEM_ADDR, 11'h055);
        step();
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0;
        @(negedge CLK);
        chk("post_clr_dbg_en", bus.MEM_EN, 1);
        chk("post_clr_dbg_we", bus.MEM_WE, 0);
        chk("post_clr_dbg_addr", bus.MEM_ADDR, 11'h010);
        @(negedge CLK);
        @(negedge CLK);
        chk("post_clr_dbg_ack", bus.DBG_ACK, 1);
        chk("post_clr_dbg_zero", bus.DBG_RDATA, 0);
        step();
        bus.DBG_REQ = 1'b0;
        cpu_read(11'h055, 32'h5555AAAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
